lcd_sign_overlay: RTL and testbench

LCD_SIGN_OVERLAY -- requirements
Module: lcd_sign_overlay

---
 rtl/lcd_pkg.sv | 36 +++
 rtl/lcd_blink_ctrl.sv | 62 ++++++
 rtl/lcd_sign_overlay.sv | 168 ++++++++++++++++
 tb/tb_lcd_sign_overlay.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module : lcd_pkg
// Shared definitions for the LCD sign overlay: pixel color width, default
// sign geometry, blink state encoding and common RGB565 color constants.
// Ports  : none (package)
// Rev    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  localparam int COLOR_W = 16;
  localparam int SIGN_W  = 16;
  localparam int SIGN_H  = 8;

  // Blink state encoding
  typedef logic [0:0] blink_state_t;
  localparam blink_state_t BLINK_SHOW = 1'b0;
  localparam blink_state_t BLINK_HIDE = 1'b1;

  // RGB565 color constants
  localparam logic [COLOR_W-1:0] RGB565_BLACK = 16'h0000;
  localparam logic [COLOR_W-1:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [COLOR_W-1:0] RGB565_RED   = 16'hF800;
  localparam logic [COLOR_W-1:0] RGB565_GREEN = 16'h07E0;
  localparam logic [COLOR_W-1:0] RGB565_BLUE  = 16'h001F;

  function automatic logic [COLOR_W-1:0] rgb565_pack(
    input logic [4:0] r,
    input logic [5:0] g,
    input logic [4:0] b
  );
    return {r, g, b};
  endfunction

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_blink_ctrl.sv
`default_nettype none
// ============================================================================
// Module : lcd_blink_ctrl
// Blink controller: counts frame_start pulses and toggles between SHOW and
// HIDE every BLINK_FRAMES frames. Disabling blinking forces SHOW and clears
// the frame counter.
// Ports  : clk, rst        - clock, synchronous active-high reset
//          blink_en_i      - blinking enable
//          frame_start_i   - one-cycle pulse per LCD frame
//          visible_o       - sign currently visible
// Rev    : 1.0 - initial release
// ============================================================================
module lcd_blink_ctrl #(
  parameter int BLINK_FRAMES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic blink_en_i,
  input  logic frame_start_i,
  output logic visible_o
);

  import lcd_pkg::*;

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  blink_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (!blink_en_i) begin
      cnt_d   = '0;
      state_d = BLINK_SHOW;
    end else if (frame_start_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = (state_q == BLINK_SHOW) ? BLINK_HIDE : BLINK_SHOW;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= BLINK_SHOW;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // Dropping blink_en shows the sign for pixels accepted in that same cycle,
  // not one cycle later when the state register has been forced to SHOW.
  assign visible_o = !blink_en_i || (state_q == BLINK_SHOW);

endmodule : lcd_blink_ctrl
`default_nettype wire

// File: rtl/lcd_sign_overlay.sv
`default_nettype none
// ============================================================================
// Module : lcd_sign_overlay
// Overlays a 1-bit sign bitmap (external ROM) onto a pixel stream. Two-stage
// valid/ready pipeline: S1 registers the request, hit flag, visibility and
// ROM address; S2 registers the composited color.
// Ports  : clk, rst                  - clock, synchronous active-high reset
//          pix_valid/pix_ready       - request handshake
//          pix_x, pix_y, bg_color    - pixel position and underlying color
//          sign_x, sign_y, fg_color  - sign placement and color
//          blink_en, frame_start     - blink control
//          rom_addr, rom_data        - external bitmap ROM
//          out_valid/out_ready       - output handshake
//          out_color                 - composited pixel
// Rev    : 1.0 - initial release
// ============================================================================
module lcd_sign_overlay #(
  parameter int ADDR_WIDTH   = 7,
  parameter int SIGN_W       = lcd_pkg::SIGN_W,
  parameter int SIGN_H       = lcd_pkg::SIGN_H,
  parameter int COLOR_W      = lcd_pkg::COLOR_W,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [8:0]            pix_x,
  input  logic [8:0]            pix_y,
  input  logic [COLOR_W-1:0]    bg_color,
  input  logic [8:0]            sign_x,
  input  logic [8:0]            sign_y,
  input  logic [COLOR_W-1:0]    fg_color,
  input  logic                  blink_en,
  input  logic                  frame_start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic                  rom_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [COLOR_W-1:0]    out_color
);

  import lcd_pkg::*;

  localparam int DX_W = (SIGN_W > 1) ? $clog2(SIGN_W) : 1;
  localparam int DY_W = (SIGN_H > 1) ? $clog2(SIGN_H) : 1;

  // --------------------------------------------------------------------------
  // Blink control
  // --------------------------------------------------------------------------
  logic visible;

  lcd_blink_ctrl #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .clk           (clk),
    .rst           (rst),
    .blink_en_i    (blink_en),
    .frame_start_i (frame_start),
    .visible_o     (visible)
  );

  // --------------------------------------------------------------------------
  // Hit test: widen to 10 bits so a sign near the right/bottom edge does not
  // wrap its end coordinate back to a small value.
  // --------------------------------------------------------------------------
  logic [9:0]            px_e, py_e, sx_e, sy_e, x_end, y_end;
  logic                  hit;
  logic [DX_W-1:0]       dx;
  logic [DY_W-1:0]       dy;
  logic [ADDR_WIDTH-1:0] addr_new;

  assign px_e  = {1'b0, pix_x};
  assign py_e  = {1'b0, pix_y};
  assign sx_e  = {1'b0, sign_x};
  assign sy_e  = {1'b0, sign_y};
  assign x_end = sx_e + 10'(SIGN_W);
  assign y_end = sy_e + 10'(SIGN_H);

  assign hit = (px_e >= sx_e) && (px_e < x_end) &&
               (py_e >= sy_e) && (py_e < y_end);

  assign dx       = DX_W'(pix_x - sign_x);
  assign dy       = DY_W'(pix_y - sign_y);
  assign addr_new = hit ? ADDR_WIDTH'({dy, dx}) : '0;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic                  s1_valid_q, s1_valid_d;
  logic                  s1_hit_q, s1_hit_d;
  logic                  s1_vis_q, s1_vis_d;
  logic [COLOR_W-1:0]    s1_fg_q, s1_fg_d;
  logic [COLOR_W-1:0]    s1_bg_q, s1_bg_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic                  out_valid_q, out_valid_d;
  logic [COLOR_W-1:0]    out_color_q, out_color_d;

  logic                  s2_free;
  logic                  accept;
  logic [COLOR_W-1:0]    s1_color;

  // S2 can take a new pixel when empty or when its pixel leaves this cycle;
  // S1 is then free to refill, giving full throughput with no bubble.
  assign s2_free   = !out_valid_q || out_ready;
  assign pix_ready = !s1_valid_q || s2_free;
  assign accept    = pix_valid && pix_ready;

  // rom_data answers for rom_addr_q, i.e. the pixel currently held in S1.
  assign s1_color = (s1_hit_q && s1_vis_q && rom_data) ? s1_fg_q : s1_bg_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_hit_d    = s1_hit_q;
    s1_vis_d    = s1_vis_q;
    s1_fg_d     = s1_fg_q;
    s1_bg_d     = s1_bg_q;
    rom_addr_d  = rom_addr_q;
    out_valid_d = out_valid_q;
    out_color_d = out_color_q;

    if (pix_ready) begin
      s1_valid_d = pix_valid;
    end
    if (accept) begin
      s1_hit_d   = hit;
      s1_vis_d   = visible;
      s1_fg_d    = fg_color;
      s1_bg_d    = bg_color;
      rom_addr_d = addr_new;
    end

    if (s2_free) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_color_d = s1_color;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_hit_q    <= 1'b0;
      s1_vis_q    <= 1'b0;
      s1_fg_q     <= '0;
      s1_bg_q     <= '0;
      rom_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_color_q <= COLOR_W'(RGB565_BLACK);
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_hit_q    <= s1_hit_d;
      s1_vis_q    <= s1_vis_d;
      s1_fg_q     <= s1_fg_d;
      s1_bg_q     <= s1_bg_d;
      rom_addr_q  <= rom_addr_d;
      out_valid_q <= out_valid_d;
      out_color_q <= out_color_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign out_valid = out_valid_q;
  assign out_color = out_color_q;

endmodule : lcd_sign_overlay
`default_nettype wire

// File: tb/tb_lcd_sign_overlay.sv
`default_nettype none
// ============================================================================
// Module : tb_lcd_sign_overlay
// Self-checking bench for lcd_sign_overlay: directed vector table, streaming
// with random back-pressure against a reference model, blink, mid-stream reset.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_lcd_sign_overlay;

  logic        clk;
  logic        rst;
  logic        pix_valid;
  logic        pix_ready;
  logic [8:0]  pix_x, pix_y;
  logic [15:0] bg_color;
  logic [8:0]  sign_x, sign_y;
  logic [15:0] fg_color;
  logic        blink_en;
  logic        frame_start;
  logic [6:0]  rom_addr;
  logic        rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_color;

  int checks   = 0;
  int failures = 0;

  lcd_sign_overlay #(
    .ADDR_WIDTH   (7),
    .SIGN_W       (16),
    .SIGN_H       (8),
    .COLOR_W      (16),
    .BLINK_FRAMES (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .bg_color    (bg_color),
    .sign_x      (sign_x),
    .sign_y      (sign_y),
    .fg_color    (fg_color),
    .blink_en    (blink_en),
    .frame_start (frame_start),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_color   (out_color)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bitmap ROM: bit set where address mod 3 == 2 (0x23 -> 1)
  function automatic bit rom_bit(input int a);
    return (a % 3) == 2;
  endfunction

  always_comb rom_data = rom_bit(int'(rom_addr));

  function automatic logic [15:0] model_color(input int px, input int py,
                                              input int sx, input int sy,
                                              input logic [15:0] fg,
                                              input logic [15:0] bg,
                                              input bit vis);
    bit hit;
    int a;
    hit = (px >= sx) && (px < sx + 16) && (py >= sy) && (py < sy + 8);
    a   = hit ? (py - sy) * 16 + (px - sx) : 0;
    return (hit && vis && rom_bit(a)) ? fg : bg;
  endfunction

  typedef struct {
    logic [8:0]  sx, sy, px, py;
    logic [15:0] fg, bg;
    logic [6:0]  exp_addr;
    logic [15:0] exp_color;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One isolated pixel through an empty pipeline; config is scrambled right
  // after acceptance to show it was captured at S1.
  task automatic run_one(input vec_t v, input string tag);
    @(negedge clk);
    sign_x    = v.sx;  sign_y   = v.sy;
    fg_color  = v.fg;  bg_color = v.bg;
    pix_x     = v.px;  pix_y    = v.py;
    pix_valid = 1'b1;  out_ready = 1'b1;
    #1;
    check({tag, "_ready"}, 32'(pix_ready), 32'd1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    fg_color  = ~v.fg;
    bg_color  = ~v.bg;
    sign_x    = v.sx + 9'd3;
    sign_y    = v.sy + 9'd1;
    check({tag, "_addr"}, 32'(rom_addr), 32'(v.exp_addr));
    check({tag, "_s1_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_color"}, 32'(out_color), 32'(v.exp_color));
    @(posedge clk); #1;
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  task automatic pulse_frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame_start = 1'b1;
      @(negedge clk); frame_start = 1'b0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[13];
    vec_t        hv;
    logic [15:0] q[$];
    int          sent, recvd, cyc;
    bit          prev_o_stall, prev_i_stall;
    logic [15:0] prev_color;
    logic [6:0]  prev_addr;

    //         sx   sy   px   py   fg        bg        addr   color
    vecs[0]  = '{100, 50, 103, 52, 16'hF800, 16'h001F, 7'h23, 16'hF800};
    vecs[1]  = '{100, 50,  99, 50, 16'hF800, 16'h001F, 7'h00, 16'h001F};
    vecs[2]  = '{100, 50, 116, 50, 16'hF800, 16'h001F, 7'h00, 16'h001F};
    vecs[3]  = '{100, 50, 100, 58, 16'hF800, 16'h001F, 7'h00, 16'h001F};
    vecs[4]  = '{100, 50, 100, 50, 16'hF800, 16'h001F, 7'h00, 16'h001F};
    vecs[5]  = '{100, 50, 113, 57, 16'hFFFF, 16'h0000, 7'h7D, 16'hFFFF};
    vecs[6]  = '{100, 50, 115, 57, 16'hFFFF, 16'h0000, 7'h7F, 16'h0000};
    vecs[7]  = '{500,  0, 510,  0, 16'h07E0, 16'h001F, 7'h0A, 16'h001F};
    vecs[8]  = '{500,  0, 511,  0, 16'h07E0, 16'h001F, 7'h0B, 16'h07E0};
    vecs[9]  = '{500,  0,   4,  0, 16'h07E0, 16'h001F, 7'h00, 16'h001F};
    vecs[10] = '{  0, 504,  4, 511, 16'hFFFF, 16'h1234, 7'h74, 16'hFFFF};
    vecs[11] = '{  0, 504,  7, 503, 16'hFFFF, 16'h1234, 7'h00, 16'h1234};
    vecs[12] = '{100, 50, 102, 50, 16'hF800, 16'h07E0, 7'h02, 16'hF800};

    hv = vecs[0];
    hv.exp_color = 16'h001F;

    rst = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; bg_color = '0;
    sign_x = '0; sign_y = '0; fg_color = '0; blink_en = 1'b0;
    frame_start = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_color", 32'(out_color), 32'd0);
    check("rst_rom_addr",  32'(rom_addr),  32'd0);
    check("rst_pix_ready", 32'(pix_ready), 32'd1);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      run_one(vecs[i], $sformatf("vec%0d", i));
    end

    // Streaming with random back-pressure
    sent = 0; recvd = 0; cyc = 0;
    prev_o_stall = 1'b0; prev_i_stall = 1'b0;
    prev_color = '0; prev_addr = '0;
    sign_x = 9'd100; sign_y = 9'd50; fg_color = 16'hF800;
    while (recvd < 64 && cyc < 2000) begin
      @(negedge clk);
      if (sent < 64) begin
        pix_valid = ($urandom_range(0, 3) != 0);
        pix_x     = 9'(96 + (sent * 5) % 24);
        pix_y     = 9'(48 + (sent * 3) % 12);
        bg_color  = 16'(sent * 257 + 1);
      end else begin
        pix_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (prev_o_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_color", 32'(out_color), 32'(prev_color));
      end
      if (prev_i_stall) begin
        check("stall_addr", 32'(rom_addr), 32'(prev_addr));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stream_extra: got 0x%0h expected no output", out_color);
        end else begin
          check("stream", 32'(out_color), 32'(q.pop_front()));
        end
        recvd++;
      end
      if (pix_valid && pix_ready) begin
        q.push_back(model_color(int'(pix_x), int'(pix_y), int'(sign_x), int'(sign_y),
                                fg_color, bg_color, 1'b1));
        sent++;
      end
      prev_o_stall = out_valid && !out_ready;
      prev_color   = out_color;
      prev_i_stall = !pix_ready;
      prev_addr    = rom_addr;
      cyc++;
    end
    check("stream_count", 32'(recvd), 32'd64);
    check("stream_left", 32'(q.size()), 32'd0);
    @(negedge clk); pix_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("stream_idle", 32'(out_valid), 32'd0);

    // Blink: 31 frames still shown
    @(negedge clk); blink_en = 1'b1;
    pulse_frames(31);
    run_one(vecs[0], "blink31");

    // 32nd frame_start lands while a shown pixel is stalled in S2
    @(negedge clk);
    sign_x = vecs[0].sx; sign_y = vecs[0].sy; fg_color = vecs[0].fg; bg_color = vecs[0].bg;
    pix_x = vecs[0].px; pix_y = vecs[0].py; pix_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk); pix_valid = 1'b0;
    @(negedge clk); frame_start = 1'b1; #1;
    check("fs_stall_valid", 32'(out_valid), 32'd1);
    check("fs_stall_color", 32'(out_color), 32'hF800);
    @(negedge clk); frame_start = 1'b0; #1;
    check("fs_hold_valid", 32'(out_valid), 32'd1);
    check("fs_hold_color", 32'(out_color), 32'hF800);
    out_ready = 1'b1;
    @(negedge clk); #1;
    check("fs_drain", 32'(out_valid), 32'd0);
    run_one(hv, "blink_hide");
    pulse_frames(32);
    run_one(vecs[0], "blink_show");
    pulse_frames(32);
    run_one(hv, "blink_hide2");

    // Reset with two pixels in flight while hidden
    @(negedge clk);
    pix_x = vecs[0].px; pix_y = vecs[0].py; pix_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); pix_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(pix_ready), 32'd1);
    check("mid_rst_addr",  32'(rom_addr),  32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("mid_rst_quiet", 32'(out_valid), 32'd0);
    end
    run_one(vecs[0], "post_rst_show");

    // Hide again, then disable blinking together with a new pixel
    pulse_frames(32);
    run_one(hv, "hide3");
    @(negedge clk); blink_en = 1'b0;
    run_one(vecs[0], "blink_off");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lcd_sign_overlay
`default_nettype wire
